// File: rtl/axis_bram_port_arbiter.sv
// Burst-locked round-robin arbiter sharing one single-port BRAM between the AXIS
// write path (W) and a read-back engine (R), with a per-grant burst watchdog.
module axis_bram_port_arbiter #(
    parameter int data_width    = 512,
    parameter int counter_width = 10,
    parameter int burst_limit   = 256,
    parameter int read_latency  = 1
) (
    input  logic                     axis_clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic                     wr_ena,
    input  logic                     wr_last,
    input  logic [counter_width-1:0] wr_address,
    input  logic [data_width-1:0]    wr_data,
    output logic                     wr_grant,
    input  logic                     rd_req,
    input  logic                     rd_ena,
    input  logic                     rd_last,
    input  logic [counter_width-1:0] rd_address,
    output logic                     rd_grant,
    output logic [data_width-1:0]    rd_dout,
    output logic                     rd_dout_valid,
    output logic                     bram_ena,
    output logic [0:0]               bram_wena,
    output logic [counter_width-1:0] bram_address,
    output logic [data_width-1:0]    bram_data,
    input  logic [data_width-1:0]    bram_dout
);

    // One-hot encoding so each grant output is a flop bit directly.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        W_OWN = 2'b01,
        R_OWN = 2'b10
    } state_t;

    localparam logic [counter_width:0] limit_ext = (counter_width + 1)'(burst_limit);

    state_t                   state_reg;
    logic                     last_owner_reg;   // 1 = R released last
    logic [counter_width-1:0] beat_cnt_reg;
    logic                     valid_pipe_reg [read_latency];

    logic                     wr_beat;
    logic                     rd_beat;
    logic [counter_width:0]   cnt_inc;
    logic                     cnt_at_limit;
    logic                     wr_release;
    logic                     rd_release;

    function automatic state_t arbitrate(input logic w, input logic r, input logic last_r);
        if (w && (!r || last_r)) begin
            return W_OWN;
        end else if (r) begin
            return R_OWN;
        end else begin
            return IDLE;
        end
    endfunction

    assign wr_grant     = state_reg[0];
    assign rd_grant     = state_reg[1];
    assign wr_beat      = wr_grant && wr_ena;
    assign rd_beat      = rd_grant && rd_ena;
    assign cnt_inc      = {1'b0, beat_cnt_reg} + (counter_width + 1)'(1);
    assign cnt_at_limit = (cnt_inc == limit_ext);
    assign wr_release   = wr_grant && (!wr_req || (wr_ena && (wr_last || cnt_at_limit)));
    assign rd_release   = rd_grant && (!rd_req || (rd_ena && (rd_last || cnt_at_limit)));

    // Release and re-arbitration share one edge, so handovers have no idle bubble.
    always_ff @(posedge axis_clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            beat_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg    <= arbitrate(wr_req, rd_req, last_owner_reg);
                    beat_cnt_reg <= '0;
                end
                W_OWN: begin
                    if (wr_release) begin
                        last_owner_reg <= 1'b0;
                        beat_cnt_reg   <= '0;
                        state_reg      <= arbitrate(wr_req, rd_req, 1'b0);
                    end else if (wr_beat) begin
                        beat_cnt_reg <= cnt_inc[counter_width-1:0];
                    end
                end
                R_OWN: begin
                    if (rd_release) begin
                        last_owner_reg <= 1'b1;
                        beat_cnt_reg   <= '0;
                        state_reg      <= arbitrate(wr_req, rd_req, 1'b1);
                    end else if (rd_beat) begin
                        beat_cnt_reg <= cnt_inc[counter_width-1:0];
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    beat_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bram_ena     = 1'b0;
        bram_wena    = 1'b0;
        bram_address = '0;
        bram_data    = '0;
        if (wr_grant) begin
            bram_ena     = wr_ena;
            bram_wena    = wr_ena;
            bram_address = wr_address;
            bram_data    = wr_data;
        end else if (rd_grant) begin
            bram_ena     = rd_ena;
            bram_address = rd_address;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!reset) begin
            valid_pipe_reg[0] <= 1'b0;
        end else begin
            valid_pipe_reg[0] <= rd_beat;
        end
    end

    generate
        for (genvar gi = 1; gi < read_latency; gi++) begin : g_valid_pipe
            always_ff @(posedge axis_clk) begin
                if (!reset) begin
                    valid_pipe_reg[gi] <= 1'b0;
                end else begin
                    valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rd_dout_valid = valid_pipe_reg[read_latency-1];
    assign rd_dout       = bram_dout;

endmodule

// File: doc/axis_bram_port_arbiter.md
# axis_bram_port_arbiter

Shares one single-port BRAM between two requesters: the AXIS write path (requester W) and a read-back engine (requester R). Grants are burst-locked: a requester keeps the port from its first beat until it transfers a beat marked last. Fairness is round-robin, and a burst-length watchdog stops either side from holding the port indefinitely. The block sits between the requesters and the BRAM port, so requester addresses and data reach the BRAM with zero added latency.

## Interface
- data_width, 512, BRAM word width
- counter_width, 10, BRAM address width
- burst_limit, 256, maximum beats per grant before forced release (≥1)
- read_latency, 1, BRAM read latency in cycles (≥1)

- axis_clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- wr_req  in  1  W requests the port
- wr_ena  in  1  W beat strobe
- wr_last  in  1  final beat of W burst
- wr_address  in  counter_width  W address
- wr_data  in  data_width  W write data
- wr_grant  out  1  W owns port (registered)
- rd_req  in  1  R requests the port
- rd_ena  in  1  R beat strobe
- rd_last  in  1  final beat of R burst
- rd_address  in  counter_width  R address
- rd_grant  out  1  R owns port (registered)
- rd_dout  out  data_width  read data (bram_dout passthrough)
- rd_dout_valid  out  1  rd_dout holds data for an R beat
- bram_ena  out  1  BRAM enable
- bram_wena  out  1 ([0:0])  BRAM write enable
- bram_address  out  counter_width  BRAM address
- bram_data  out  data_width  BRAM write data
- bram_dout  in  data_width  BRAM read data

## Operation
- States: IDLE, W_OWN, R_OWN. wr_grant = (state==W_OWN); rd_grant = (state==R_OWN). Never both high.
- last_owner flag: reset value R, so W wins the first contest.
- Arbitration, used in IDLE and at every release:
  - one requester → it wins;
  - both → the one that is not last_owner wins;
  - none → IDLE.
- Beat: grant && own ena. An ena without a grant is ignored, with no BRAM access.
- BRAM mux:
  - W_OWN: bram_ena=wr_ena, bram_wena=wr_ena, bram_address=wr_address, bram_data=wr_data.
  - R_OWN: bram_ena=rd_ena, bram_wena=0, bram_address=rd_address, bram_data=0.
  - IDLE: all zero.
- beat_cnt (counter_width bits) resets to 0 on every grant change and increments per beat.
- Release from owner state, with arbitration the next cycle, occurs when any of these holds:
  - a beat with own last;
  - own req low (abort, no beat needed);
  - the beat that makes beat_cnt reach burst_limit.
- On release, last_owner is set to the releasing requester. A forced release means a still-requesting owner loses to a pending opponent.
- Handover: release and the new grant happen on the same edge, so there is no idle bubble between bursts.
- rd_dout_valid: a read_latency-deep shift of (R beat). rd_dout = bram_dout, unregistered.

## Timing
- After reset (reset=0 sampled): state IDLE, grants 0, beat_cnt 0, valid pipe 0.
  - BRAM outputs are therefore 0, and rd_dout_valid is 0.
- Request latency: req high in IDLE at edge N gives grant high after edge N, visible in cycle N+1. The first beat is possible in cycle N+1.
- A last beat in cycle K gives a grant drop or handover at edge K+1.
- A read beat in cycle K gives rd_dout_valid=1 in cycle K+read_latency.
- Reset mid-burst:
  - grants drop after the reset edge;
  - in-flight rd_dout_valid bits are flushed;
  - the requester must restart its burst.
- Simultaneous last and opponent req: handover at the next edge.
- Simultaneous last and own req still high with no opponent: re-grant to same requester; beat_cnt cleared.

## Test plan
- Reset hold 5 cycles, then reset=1 with no reqs → all outputs 0, state IDLE.
- wr_req=1, 4 beats to addr 0..3 with data 0xA0..0xA3, last on beat 4 → wr_grant 1 cycle after req, bram_wena=1 ×4, grant drops after last.
- wr_req and rd_req asserted same cycle after reset → W granted first. After W last, R is granted on the next edge with no bubble. A read of addr 2 returns 0xA2 with rd_dout_valid exactly read_latency cycles later.
- burst_limit=4, W streams 10 beats without last while rd_req=1 → W is forced off after beat 4, R is granted, and W is regranted after R's last.
- rd_ena pulsed while rd_grant=0 → bram_ena stays 0, no rd_dout_valid.
- Reset asserted mid W burst at beat 2 of 8 → grant 0 next cycle, no further BRAM writes, W wins the first contest after reset.
